// File: rtl/fifo_frame_reader.sv
// Drains the upstream FIFO through a 2-entry skid buffer, parses header/payload/checksum
// frames and forwards payload words on a valid/ready stream with per-frame status pulses.
module fifo_frame_reader #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned MAX_LEN = 255
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd,
   output logic [15:0]      m_data,
   output logic [7:0]       m_opcode,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_first,
   output logic             m_last,
   output logic             frame_ok,
   output logic             frame_err,
   output logic [1:0]       err_code,
   output logic [7:0]       err_count
);

   typedef enum logic [1:0] {
      StHdr,
      StPayload,
      StCheck
   } state_e;

   state_e      state_q;
   logic [15:0] buf_mem_q [2];
   logic        rd_ptr_q;
   logic [1:0]  occ_q;
   logic        pend_q;
   logic        run_q;
   logic [15:0] sum_q;
   logic [7:0]  cnt_q;
   logic        first_q;

   logic [15:0] head;
   logic        has_head;
   logic        pop;
   logic        beat;
   logic [1:0]  occ_after;
   logic        wr_ptr;
   logic        bad_len;

   // Only the low 16 bits carry frame data.
   logic unused_dout;
   assign unused_dout = ^fifo_dout;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign head     = buf_mem_q[rd_ptr_q];
   assign has_head = (occ_q != 2'd0);
   assign bad_len  = (head[7:0] == 8'd0) || (32'(head[7:0]) > MAX_LEN);

   // Buffer head drives the stream only while a payload beat is pending.
   always_comb begin
      m_valid = (state_q == StPayload) && has_head;
      beat    = m_valid && m_ready;
      m_data  = m_valid ? head : 16'h0000;
      m_first = m_valid && first_q;
      m_last  = m_valid && (cnt_q == 8'd1);
   end

   // Decide whether the head word is consumed this cycle.
   always_comb begin
      pop = 1'b0;
      if (has_head) begin
         unique case (state_q)
            StHdr:     pop = 1'b1;
            StPayload: pop = m_ready;
            StCheck:   pop = 1'b1;
            default:   pop = 1'b0;
         endcase
      end
   end

   // Occupancy counts the slot freed by this cycle's pop so a full-rate stream keeps one
   // word buffered and one in flight. run_q holds reads off for the first cycle out of reset.
   always_comb begin
      occ_after = occ_q - {1'b0, pop};
      wr_ptr    = rd_ptr_q ^ occ_q[0];
      fifo_rd   = reset_n && run_q && !fifo_empty &&
                  (({1'b0, occ_after} + {2'b00, pend_q}) < 3'd2);
   end

   // Skid buffer: capture the word read last cycle and advance on pop.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         occ_q    <= 2'd0;
         rd_ptr_q <= 1'b0;
         pend_q   <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         run_q  <= 1'b1;
         pend_q <= fifo_rd;
         if (pend_q) begin
            buf_mem_q[wr_ptr] <= fifo_dout[15:0];
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_q - {1'b0, pop} + {1'b0, pend_q};
      end
   end

   // Frame parser with registered opcode and status outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= StHdr;
         m_opcode  <= 8'h00;
         sum_q     <= 16'h0000;
         cnt_q     <= 8'h00;
         first_q   <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'd0;
         err_count <= 8'h00;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'd0;
         unique case (state_q)
            StHdr: begin
               if (has_head) begin
                  m_opcode <= head[15:8];
                  sum_q    <= head;
                  cnt_q    <= head[7:0];
                  first_q  <= 1'b1;
                  if (bad_len) begin
                     frame_err <= 1'b1;
                     err_code  <= 2'd1;
                     err_count <= sat_inc(err_count);
                  end else begin
                     state_q <= StPayload;
                  end
               end
            end
            StPayload: begin
               if (beat) begin
                  sum_q   <= sum_q + head;
                  cnt_q   <= cnt_q - 8'd1;
                  first_q <= 1'b0;
                  if (cnt_q == 8'd1) begin
                     state_q <= StCheck;
                  end
               end
            end
            StCheck: begin
               if (has_head) begin
                  state_q <= StHdr;
                  if (head == sum_q) begin
                     frame_ok <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= 2'd2;
                     err_count <= sat_inc(err_count);
                  end
               end
            end
            default: state_q <= StHdr;
         endcase
      end
   end

endmodule

// File: doc/fifo_frame_reader.md
Name: fifo_frame_reader

Overview:
- Sits directly downstream of the driver board's FIFO wrapper and drains it: `fifo_rd` out, `fifo_empty` and `fifo_dout` in.
- Parses the word stream into command frames of the form header, payload words, checksum.
- Forwards payload words on a valid/ready stream to the motor command logic.
- Flags checksum and length errors per frame.

Parameters:
- WIDTH, 16, FIFO word width. Must be >= 16; only bits [15:0] are parsed, upper bits are ignored.
- MAX_LEN, 255, maximum legal payload length in words (1..255).

Ports:
- clock  input  1  system clock; the FIFO read clock is driven from the same clock.
- reset_n  input  1  synchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  WIDTH  FIFO read data; valid one cycle after a `fifo_rd` issued while `fifo_empty`=0 (no output pipe).
- fifo_rd  output  1  FIFO read strobe.
- m_data  output  16  payload word.
- m_opcode  output  8  opcode of the current frame; held for the whole frame.
- m_valid  output  1  payload beat valid.
- m_ready  input  1  consumer accepts beat.
- m_first  output  1  first payload beat of a frame.
- m_last  output  1  last payload beat of a frame.
- frame_ok  output  1  one-cycle pulse: frame completed, checksum good.
- frame_err  output  1  one-cycle pulse: frame rejected.
- err_code  output  2  error cause, valid with `frame_err`: 1 = bad length, 2 = checksum.
- err_count  output  8  saturating count of `frame_err` pulses.

Behaviour:
- Reset: all outputs 0, FSM in HDR, buffer empty, in-flight read discarded. Reset mid-frame abandons the frame silently (no `frame_err`); the next word read is treated as a header.
- Prefetch:
  - 2-entry skid buffer; `fifo_rd` = !`fifo_empty` && (occupancy + in-flight) < 2.
  - Read data is written into the buffer the cycle after `fifo_rd`.
  - `fifo_rd` is never asserted while `fifo_empty`=1.
  - Sustains 1 word/cycle with `m_ready` held high.
- Header word:
  - opcode = [15:8], len = [7:0].
  - Header is consumed in the cycle it sits at the buffer head.
  - `m_opcode` is latched, `sum` is set to the header value, `cnt` is set to len.
- FSM states:
  - HDR: consume header. If len==0 or len>MAX_LEN, pulse `frame_err` with `err_code`=1 next cycle and stay in HDR (no checksum word is expected). Otherwise go to PAYLOAD.
  - PAYLOAD: the buffer head drives `m_data`/`m_valid`. A beat transfers on `m_valid`&&`m_ready`, which pops the buffer, adds the word to `sum` (16-bit, wraps mod 2^16) and decrements `cnt`.
    - `m_first`=1 on the first beat only.
    - `m_last`=1 when `cnt`==1.
    - After the last beat, go to CHECK.
  - CHECK: consume the checksum word.
    - If equal to `sum`: pulse `frame_ok`.
    - Else: pulse `frame_err` with `err_code`=2.
    - Pulse occurs the cycle after consumption; go to HDR.
- Payload beats are forwarded before the check; consumers discard the frame on `frame_err`.
- `m_valid` never deasserts without a transfer once asserted, and `m_data` is stable while `m_valid` && !`m_ready`. `m_valid`=0 in HDR and CHECK.
- `err_count` increments on each `frame_err` and saturates at 255. It is cleared only by reset.
- `frame_ok` and `frame_err` are never asserted together.
- If the FIFO runs empty mid-frame, the FSM waits in its state indefinitely; there is no timeout.

Test Plan:
- FIFO holds 0x0A03, 0x1111, 0x2222, 0x3333, 0x7069; `m_ready`=1 -> 3 beats 0x1111 (`m_first`), 0x2222, 0x3333 (`m_last`), `m_opcode`=0x0A; `frame_ok` pulse; `err_count`=0; beats on consecutive cycles.
- Same frame with checksum 0x7068 -> same 3 beats forwarded; `frame_err`=1, `err_code`=2, `err_count`=1; no `frame_ok`.
- FIFO holds 0x0500 followed by a valid frame -> `frame_err` with `err_code`=1 and no beats for the first word; the following frame is delivered with `frame_ok`.
- Two back-to-back valid frames with `m_ready` randomly toggled ~50% -> payload order preserved, `m_data` stable while stalled, `fifo_rd` never high with `fifo_empty`=1, occupancy + in-flight <= 2.
- `reset_n`=0 for 1 cycle during the 2nd payload beat -> all outputs 0 next cycle; a subsequent valid frame parses with `frame_ok` and no `frame_err` for the abandoned frame.
- 260 frames with bad checksum -> `err_count` reaches 255 and holds.
